keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces whole scan rounds,
// and shifts each accepted key code into a four-digit number register.
module keypad_scanner #(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        on,
  input  logic        clear,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] number,
  output logic        key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  function automatic logic [2:0] count_low(input logic [3:0] r);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Low-row tally only needs to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s >= 4'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [3:0]       row_p1, row_p2;
  logic [DIV_W-1:0] div;
  logic [1:0]       colidx;
  logic [1:0]       low_acc;
  logic [3:0]       acc_code;
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [3:0]       cand;

  logic [2:0] samp_low;
  logic [1:0] samp_row;
  logic [1:0] round_low;
  logic [3:0] round_code;
  logic       sample_tick, round_end;
  logic       r_none, r_single;

  assign col = on ? ~(4'b0001 << colidx) : 4'b1111;

  // Stage p1/p2: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (reset) begin
      row_p1 <= 4'b1111;
      row_p2 <= 4'b1111;
    end else begin
      row_p1 <= row;
      row_p2 <= row_p1;
    end
  end

  always_comb begin
    samp_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_p2[r]) samp_row = 2'(r);
    end
  end

  assign samp_low    = count_low(row_p2);
  assign round_low   = sat_add(low_acc, samp_low);
  assign round_code  = (low_acc != 2'd0) ? acc_code : {samp_row, colidx};
  assign sample_tick = on && (div == DIV_LAST);
  assign round_end   = sample_tick && (colidx == 2'd3);
  assign r_none      = (round_low == 2'd0);
  assign r_single    = (round_low == 2'd1);

  // Column walk and per-round accumulation of sampled low rows
  always_ff @(posedge clk) begin
    if (reset || !on) begin
      div      <= '0;
      colidx   <= 2'd0;
      low_acc  <= 2'd0;
      acc_code <= 4'd0;
    end else if (div == DIV_LAST) begin
      div    <= '0;
      colidx <= colidx + 2'd1;
      if (colidx == 2'd3) begin
        low_acc  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        low_acc  <= round_low;
        acc_code <= round_code;
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Round-level debounce FSM; outputs are registered with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      cand      <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      number    <= 16'h0000;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (clear) number <= 16'h0000;
      if (!on) begin
        state    <= S_IDLE;
        count    <= '0;
        key_held <= 1'b0;
      end else if (round_end) begin
        case (state)
          S_IDLE: begin
            if (r_single) begin
              cand <= round_code;
              if (DEBOUNCE <= 1) begin
                key_valid <= 1'b1;
                key_code  <= round_code;
                if (!clear) number <= {number[11:0], round_code};
                state    <= S_HELD;
                key_held <= 1'b1;
                count    <= '0;
              end else begin
                state <= S_DEBOUNCE;
                count <= CNT_W'(1);
              end
            end
          end
          S_DEBOUNCE: begin
            if (r_single && round_code == cand) begin
              if (count >= DEB_LAST) begin
                key_valid <= 1'b1;
                key_code  <= round_code;
                if (!clear) number <= {number[11:0], round_code};
                state    <= S_HELD;
                key_held <= 1'b1;
                count    <= '0;
              end else begin
                count <= count + CNT_W'(1);
              end
            end else if (r_single) begin
              cand  <= round_code;
              count <= CNT_W'(1);
            end else begin
              state <= S_IDLE;
              count <= '0;
            end
          end
          S_HELD: begin
            if (r_none) begin
              if (DEBOUNCE <= 1) begin
                state    <= S_IDLE;
                key_held <= 1'b0;
                count    <= '0;
              end else begin
                state <= S_RELEASE;
                count <= CNT_W'(1);
              end
            end
          end
          S_RELEASE: begin
            if (r_none) begin
              if (count >= DEB_LAST) begin
                state    <= S_IDLE;
                key_held <= 1'b0;
                count    <= '0;
              end else begin
                count <= count + CNT_W'(1);
              end
            end else begin
              state <= S_HELD;
              count <= '0;
            end
          end
          default: begin
            state    <= S_IDLE;
            count    <= '0;
            key_held <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 and a modelled key matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset, on, clear;
  logic [3:0]  row, col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] number;
  logic        key_held;
  logic [15:0] pressed;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic        dropped;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .reset(reset), .on(on), .clear(clear), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code), .number(number), .key_held(key_held)
  );

  // Key matrix: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int code, input int hold, input int gap);
    pressed = 16'h0001 << code;
    cyc(hold);
    pressed = 16'h0000;
    cyc(gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_col;
    bit found;
    reset = 1'b1; on = 1'b1; clear = 1'b0; pressed = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_kv", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_num", number, 0);
    chk("rst_held", key_held, 0);
    chk("col_0", col, 4'b1110);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (i / 4));
      chk("col_walk", col, exp_col);
    end
    cyc(32);
    chk("idle_pulses", pulses, 0);
    chk("idle_num", number, 0);

    pressed = 16'h0001 << 6;
    cyc(56);
    chk("k6_pulses", pulses, 1);
    chk("k6_code", key_code, 6);
    chk("k6_num", number, 16'h0006);
    chk("k6_held", key_held, 1);
    cyc(32);
    chk("k6_norepeat", pulses, 1);
    pressed = 16'h0000;
    cyc(56);
    chk("k6_release", key_held, 0);

    press_key(1, 56, 56);
    press_key(2, 56, 56);
    press_key(3, 56, 56);
    press_key(4, 56, 56);
    chk("seq_num", number, 16'h1234);
    chk("seq_pulses", pulses, 5);
    press_key(10, 56, 56);
    chk("keyA_num", number, 16'h234A);
    chk("keyA_code", key_code, 4'hA);
    chk("keyA_pulses", pulses, 6);

    pressed = 16'h8001;
    cyc(64);
    pressed = 16'h0000;
    cyc(56);
    chk("multi_pulses", pulses, 6);
    chk("multi_num", number, 16'h234A);
    chk("multi_held", key_held, 0);

    on = 1'b0;
    #1 chk("off_col", col, 4'b1111);
    cyc(20);
    chk("off_num", number, 16'h234A);
    chk("off_code", key_code, 4'hA);
    chk("off_kv", key_valid, 0);
    @(posedge clk);
    #1 on = 1'b1;
    @(negedge clk);
    chk("on_col0", col, 4'b1110);
    cyc(4);
    chk("on_col1", col, 4'b1101);

    for (int i = 0; i < 4; i++) press_key(7, 16, 16);
    cyc(40);
    chk("bounce_pulses", pulses, 6);
    chk("bounce_held", key_held, 0);

    pressed = 16'h0001 << 9;
    cyc(56);
    chk("k9_pulses", pulses, 7);
    chk("k9_num", number, 16'h34A9);
    chk("k9_held", key_held, 1);
    dropped = 1'b0;
    pressed = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    pressed = 16'h0001 << 9;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    chk("glitch_held", dropped, 0);
    chk("glitch_pulses", pulses, 7);
    pressed = 16'h0000;
    cyc(56);
    chk("k9_release", key_held, 0);

    press_key(1, 56, 56);
    press_key(2, 56, 56);
    press_key(3, 56, 56);
    press_key(4, 56, 56);
    chk("seq2_num", number, 16'h1234);

    clear = 1'b1;
    pressed = 16'h0001 << 5;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) found = 1'b1;
    end
    clear = 1'b0;
    if (found) begin
      chk("clr_num", number, 0);
      chk("clr_code", key_code, 5);
    end else begin
      chk("k5_timeout", 0, 1);
    end
    cyc(2);
    chk("clr_after", number, 0);
    pressed = 16'h0000;
    cyc(56);
    chk("k5_pulses", pulses, 12);

    pressed = 16'h0001 << 8;
    cyc(24);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_kv", key_valid, 0);
    chk("mid_code", key_code, 0);
    chk("mid_num", number, 0);
    chk("mid_held", key_held, 0);
    chk("mid_col", col, 4'b1110);
    cyc(8);
    pressed = 16'h0000;
    cyc(56);
    chk("mid_pulses", pulses, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
